// File: rtl/znmi_pkg.sv
// Shared types and constants for the Z80 NMI controller.
// State encoding, imm-request cause code, NMI vector, priority pick.
package znmi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT66,
    S_PAGED,
    S_CLRWAIT
  } state_t;

  localparam logic [3:0]  CAUSE_IMM  = 4'hF;
  localparam logic [15:0] NMI_VECTOR = 16'h0066;

  function automatic logic [3:0] first_set(
    input logic [7:0] v
  );
    first_set = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) first_set = 4'(i);
  endfunction

endpackage

// File: rtl/znmi_busmon.sv
// Z80 bus monitor: M1 fetch tracking and refresh falling-edge
// detection, both sampled on the Z80 clock strobes.
module znmi_busmon
  import znmi_pkg::*;
(
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        zpos,
  input  logic        zneg,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        rfsh_n,
  input  logic        csrom,
  input  logic [15:0] a,
  output logic        fetch_edge,
  output logic        last_0066,
  output logic        last_rom,
  output logic        rfsh_fall
);

  logic m1_q, m1_d;
  logic mreq_q, mreq_d;
  logic both_q, both_d;
  logic l66_q, l66_d;
  logic lrom_q, lrom_d;
  logic r1_q, r1_d;
  logic r2_q, r2_d;
  logic fall_q, fall_d;

  always_comb begin
    m1_d       = zpos ? m1_n : m1_q;
    mreq_d     = zneg ? mreq_n : mreq_q;
    both_d     = !m1_q && !mreq_q;
    fetch_edge = both_d && !both_q;
    l66_d      = l66_q;
    lrom_d     = lrom_q;
    if (fetch_edge) begin
      l66_d  = (a == NMI_VECTOR);
      lrom_d = csrom && (a[15:14] == 2'b00);
    end
    // two-stage refresh sampler; fall flagged for one fclk
    r1_d   = zpos ? rfsh_n : r1_q;
    r2_d   = zpos ? r1_q : r2_q;
    fall_d = zpos && r2_q && !r1_q;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      m1_q   <= 1'b1;
      mreq_q <= 1'b1;
      both_q <= 1'b0;
      l66_q  <= 1'b0;
      lrom_q <= 1'b0;
      r1_q   <= 1'b1;
      r2_q   <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      m1_q   <= m1_d;
      mreq_q <= mreq_d;
      both_q <= both_d;
      l66_q  <= l66_d;
      lrom_q <= lrom_d;
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      fall_q <= fall_d;
    end
  end

  assign last_0066 = l66_q;
  assign last_rom  = lrom_q;
  assign rfsh_fall = fall_q;

endmodule

// File: rtl/znmi_ctrl.sv
// Z80 NMI controller: deferred/immediate requests, NMI pulse, page-in.
// Optional watchdog on the 0066 fetch enabled by ZNMI_WATCHDOG_EN.
module znmi_ctrl
  import znmi_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int PULSE_LEN = 4,
  parameter int CLR_RFSH  = 2,
  parameter int WDT_LEN   = 255
) (
  input  logic           fclk,
  input  logic           rst_n,
  input  logic           zpos,
  input  logic           zneg,
  input  logic           int_start,
  input  logic [NCH-1:0] req_n,
  input  logic [NCH-1:0] req_mask,
  input  logic           imm_nmi,
  input  logic           clr_nmi,
  input  logic           rfsh_n,
  input  logic           m1_n,
  input  logic           mreq_n,
  input  logic           csrom,
  input  logic [15:0]    a,
  output logic           drive_00,
  output logic           in_nmi,
  output logic           gen_nmi,
  output logic           nmi_buf_clr,
  output logic [3:0]     nmi_cause,
  output logic           nmi_abort
);

  state_t state_q, state_d;

  logic [NCH-1:0] req_q;
  logic           imm_q;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] ev, clr;
  logic [3:0]     cause_q, cause_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     win;
  logic           imm_ev;

  logic fetch_edge, last_0066, last_rom, rfsh_fall;
  logic unused_ok;

  znmi_busmon u_busmon (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .zpos       (zpos),
    .zneg       (zneg),
    .m1_n       (m1_n),
    .mreq_n     (mreq_n),
    .rfsh_n     (rfsh_n),
    .csrom      (csrom),
    .a          (a),
    .fetch_edge (fetch_edge),
    .last_0066  (last_0066),
    .last_rom   (last_rom),
    .rfsh_fall  (rfsh_fall)
  );

  assign unused_ok = ^{fetch_edge, last_rom, (WDT_LEN != 0)};

`ifdef ZNMI_WATCHDOG_EN
  localparam int WW = $clog2(WDT_LEN + 1);
  logic [WW-1:0] wdt_q, wdt_d;
  logic          abort_q, abort_d;
  logic          busy;
`endif

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    ev      = req_q & ~req_n & req_mask;
    imm_ev  = imm_nmi && !imm_q;
    win     = first_set(8'(pend_q));
    clr     = '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        // immediate request outranks a frame-start deferred one
        if (imm_ev) begin
          state_d = S_PULSE;
          cnt_d   = 4'(PULSE_LEN);
          cause_d = CAUSE_IMM;
        end else if (int_start && (|pend_q)) begin
          state_d = S_PULSE;
          cnt_d   = 4'(PULSE_LEN);
          cause_d = win;
          for (int i = 0; i < NCH; i++)
            clr[i] = (win == 4'(i));
        end
      end
      S_PULSE: begin
        if (zpos) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_WAIT66;
        end
      end
      S_WAIT66: begin
        if (rfsh_fall && last_0066) state_d = S_PAGED;
      end
      S_PAGED: begin
        if (clr_nmi) begin
          state_d = S_CLRWAIT;
          cnt_d   = 4'(CLR_RFSH);
        end
      end
      S_CLRWAIT: begin
        if (clr_nmi) begin
          cnt_d = 4'(CLR_RFSH);
        end else if (rfsh_fall) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pend_d = (pend_q & ~clr) | ev;
`ifdef ZNMI_WATCHDOG_EN
    busy    = (state_q == S_PULSE) || (state_q == S_WAIT66);
    abort_d = 1'b0;
    wdt_d   = wdt_q;
    if (busy && zpos) wdt_d = wdt_q + WW'(1);
    if (busy && (wdt_d == WW'(WDT_LEN))) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
    end
    if (state_d != state_q) wdt_d = '0;
`endif
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '1;
      imm_q   <= 1'b0;
      pend_q  <= '0;
      cause_q <= 4'd0;
      cnt_q   <= 4'd0;
    end else begin
      req_q   <= req_n;
      imm_q   <= imm_nmi;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ZNMI_WATCHDOG_EN
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      abort_q <= abort_d;
    end
  end
`endif

  always_comb begin
    gen_nmi     = (state_q == S_PULSE);
    in_nmi      = (state_q == S_PAGED) ||
                  (state_q == S_CLRWAIT);
    nmi_buf_clr = ((state_q == S_PULSE) ||
                   (state_q == S_WAIT66)) && last_0066;
    drive_00    = nmi_buf_clr && !m1_n && !mreq_n;
    nmi_cause   = cause_q;
`ifdef ZNMI_WATCHDOG_EN
    nmi_abort   = abort_q;
`else
    nmi_abort   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_znmi_ctrl.sv
// Self-checking bench for znmi_ctrl: vector table, hand sequences,
// and random request traffic against a pending-set model.
module tb_znmi_ctrl;

  localparam int NCH = 4;

  logic           fclk = 1'b0;
  logic           rst_n;
  logic           zpos = 1'b0;
  logic           zneg = 1'b0;
  logic           int_start;
  logic [NCH-1:0] req_n;
  logic [NCH-1:0] req_mask;
  logic           imm_nmi;
  logic           clr_nmi;
  logic           rfsh_n;
  logic           m1_n;
  logic           mreq_n;
  logic           csrom;
  logic [15:0]    a;
  logic           drive_00;
  logic           in_nmi;
  logic           gen_nmi;
  logic           nmi_buf_clr;
  logic [3:0]     nmi_cause;
  logic           nmi_abort;

  int n_chk = 0;
  int n_fail = 0;
  int ph = 0;
  int abort_cnt = 0;

  typedef struct {
    logic [3:0] fall;
    logic [3:0] mask;
    logic       imm;
    logic       nmi1;
    logic [3:0] c1;
    logic       nmi2;
    logic [3:0] c2;
  } vec_t;

  vec_t vt[7];

  znmi_ctrl #(
    .NCH       (NCH),
    .PULSE_LEN (4),
    .CLR_RFSH  (2),
    .WDT_LEN   (255)
  ) dut (
    .fclk        (fclk),
    .rst_n       (rst_n),
    .zpos        (zpos),
    .zneg        (zneg),
    .int_start   (int_start),
    .req_n       (req_n),
    .req_mask    (req_mask),
    .imm_nmi     (imm_nmi),
    .clr_nmi     (clr_nmi),
    .rfsh_n      (rfsh_n),
    .m1_n        (m1_n),
    .mreq_n      (mreq_n),
    .csrom       (csrom),
    .a           (a),
    .drive_00    (drive_00),
    .in_nmi      (in_nmi),
    .gen_nmi     (gen_nmi),
    .nmi_buf_clr (nmi_buf_clr),
    .nmi_cause   (nmi_cause),
    .nmi_abort   (nmi_abort)
  );

  always #5 fclk = ~fclk;

  // Z80 clock strobes: zpos every 4th fclk, zneg halfway between
  initial forever begin
    @(posedge fclk);
    #2;
    ph   = ph + 1;
    zpos = (ph % 4 == 0);
    zneg = (ph % 4 == 2);
  end

  initial forever begin
    @(negedge fclk);
    if (nmi_abort) abort_cnt++;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic idle_inputs;
    int_start = 1'b0;
    imm_nmi   = 1'b0;
    clr_nmi   = 1'b0;
    rfsh_n    = 1'b1;
    m1_n      = 1'b1;
    mreq_n    = 1'b1;
    csrom     = 1'b0;
    a         = 16'h0000;
    req_n     = '1;
    req_mask  = '1;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
  endtask

  task automatic req_fall(input logic [3:0] f);
    req_n = ~f;
    cyc(3);
    req_n = '1;
    cyc(1);
  endtask

  task automatic start_nmi(input logic di, input logic dm,
                           output logic seen, output int w);
    seen      = 1'b0;
    w         = 0;
    int_start = di;
    imm_nmi   = dm;
    cyc(1);
    int_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge fclk);
      if (gen_nmi) begin
        seen = 1'b1;
        if (zpos) w++;
      end else if (seen) begin
        break;
      end
    end
    imm_nmi = 1'b0;
    cyc(1);
  endtask

  task automatic fetch(input logic [15:0] addr, output logic d00);
    a      = addr;
    m1_n   = 1'b0;
    mreq_n = 1'b0;
    cyc(10);
    @(negedge fclk);
    d00 = drive_00;
    cyc(1);
    m1_n   = 1'b1;
    mreq_n = 1'b1;
    cyc(10);
  endtask

  task automatic rfsh_pulse;
    rfsh_n = 1'b0;
    cyc(12);
    rfsh_n = 1'b1;
    cyc(12);
  endtask

  // Handler from WAIT66 back to IDLE, with stray requests while paged
  task automatic handler(input logic [3:0] mid);
    logic d;
    fetch(16'h0066, d);
    chk("drive_00_m1", d, 1);
    @(negedge fclk);
    chk("buf_clr", nmi_buf_clr, 1);
    chk("drive_00_off", drive_00, 0);
    chk("in_nmi_pre", in_nmi, 0);
    rfsh_pulse();
    @(negedge fclk);
    chk("in_nmi_paged", in_nmi, 1);
    cyc(1);
    fetch(16'h0100, d);
    req_n   = ~mid;
    imm_nmi = 1'b1;
    cyc(3);
    req_n   = '1;
    imm_nmi = 1'b0;
    cyc(1);
    @(negedge fclk);
    chk("imm_in_paged", gen_nmi, 0);
    cyc(1);
    clr_nmi = 1'b1;
    cyc(1);
    clr_nmi = 1'b0;
    cyc(2);
    rfsh_pulse();
    @(negedge fclk);
    chk("in_nmi_clr1", in_nmi, 1);
    cyc(1);
    rfsh_pulse();
    @(negedge fclk);
    chk("in_nmi_clr2", in_nmi, 0);
    cyc(1);
  endtask

  initial begin
    logic       seen;
    int         w;
    logic       d;
    logic [3:0] mp;

    vt[0] = '{4'b0100, 4'b1111, 1'b0, 1'b1, 4'd2, 1'b0, 4'd0};
    vt[1] = '{4'b1010, 4'b1111, 1'b0, 1'b1, 4'd1, 1'b1, 4'd3};
    vt[2] = '{4'b0001, 4'b1110, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0};
    vt[3] = '{4'b0000, 4'b1111, 1'b1, 1'b1, 4'hF, 1'b0, 4'd0};
    vt[4] = '{4'b0001, 4'b1111, 1'b1, 1'b1, 4'hF, 1'b1, 4'd0};
    vt[5] = '{4'b1100, 4'b0111, 1'b0, 1'b1, 4'd2, 1'b0, 4'd0};
    vt[6] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'd0, 1'b1, 4'd1};

    idle_inputs();
    rst_n = 1'b0;
    cyc(2);
    @(negedge fclk);
    chk("rst_drive_00", drive_00, 0);
    chk("rst_in_nmi", in_nmi, 0);
    chk("rst_gen_nmi", gen_nmi, 0);
    chk("rst_buf_clr", nmi_buf_clr, 0);
    chk("rst_cause", nmi_cause, 0);
    chk("rst_abort", nmi_abort, 0);
    rst_n = 1'b1;
    cyc(3);

    foreach (vt[k]) begin
      do_reset();
      req_mask = vt[k].mask;
      req_fall(vt[k].fall);
      cyc(100);
      start_nmi(1'b1, vt[k].imm, seen, w);
      chk($sformatf("v%0d_start1", k), seen, vt[k].nmi1);
      if (vt[k].nmi1) begin
        chk($sformatf("v%0d_cause1", k), nmi_cause, vt[k].c1);
        chk($sformatf("v%0d_width1", k), w, 4);
        handler(4'b0000);
      end
      start_nmi(1'b1, 1'b0, seen, w);
      chk($sformatf("v%0d_start2", k), seen, vt[k].nmi2);
      if (vt[k].nmi2) begin
        chk($sformatf("v%0d_cause2", k), nmi_cause, vt[k].c2);
        chk($sformatf("v%0d_width2", k), w, 4);
        handler(4'b0000);
      end else if (vt[k].nmi1) begin
        chk($sformatf("v%0d_cause_hold", k), nmi_cause, vt[k].c1);
      end
    end

    // clr_nmi in WAIT66, then a long stall with no 0066 fetch
    do_reset();
    abort_cnt = 0;
    start_nmi(1'b0, 1'b1, seen, w);
    chk("stall_start", seen, 1);
    clr_nmi = 1'b1;
    cyc(1);
    clr_nmi = 1'b0;
    @(negedge fclk);
    chk("clr_in_wait66", in_nmi, 0);
    cyc(1200);
    @(negedge fclk);
`ifdef ZNMI_WATCHDOG_EN
    chk("wdt_abort_cnt", abort_cnt, 1);
    chk("wdt_in_nmi", in_nmi, 0);
    cyc(1);
    start_nmi(1'b0, 1'b1, seen, w);
    chk("wdt_back_idle", seen, 1);
    handler(4'b0000);
`else
    chk("hold_no_abort", abort_cnt, 0);
    chk("hold_gen_nmi", gen_nmi, 0);
    chk("hold_in_nmi", in_nmi, 0);
    cyc(1);
    handler(4'b0000);
`endif

    // reset while paged; pending request must be dropped too
    do_reset();
    req_fall(4'b0010);
    start_nmi(1'b0, 1'b1, seen, w);
    chk("rp_cause", nmi_cause, 4'hF);
    fetch(16'h0066, d);
    rfsh_pulse();
    @(negedge fclk);
    chk("rp_paged", in_nmi, 1);
    @(posedge fclk);
    #1;
    m1_n   = 1'b0;
    mreq_n = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rp_in_nmi", in_nmi, 0);
    chk("rp_gen_nmi", gen_nmi, 0);
    chk("rp_drive_00", drive_00, 0);
    m1_n   = 1'b1;
    mreq_n = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    start_nmi(1'b1, 1'b0, seen, w);
    chk("rp_no_nmi", seen, 0);

    // reset during the pulse
    start_nmi(1'b0, 1'b0, seen, w);
    imm_nmi = 1'b1;
    cyc(2);
    chk("rpl_pulse_on", gen_nmi, 1);
    rst_n = 1'b0;
    #1;
    chk("rpl_gen_off", gen_nmi, 0);
    imm_nmi = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    start_nmi(1'b0, 1'b0, seen, w);
    chk("rpl_no_nmi", seen, 0);

    // random traffic vs. pending-set model
    do_reset();
    mp = '0;
    for (int r = 0; r < 30; r++) begin
      logic [3:0] m, f, mid, ec;
      logic       di, dm, en;
      int         widx;
      m        = 4'($urandom);
      f        = 4'($urandom);
      req_mask = m;
      mp       = mp | (f & m);
      req_fall(f);
      cyc($urandom_range(5, 40));
      di   = ($urandom_range(0, 3) != 0);
      dm   = ($urandom_range(0, 3) == 0);
      en   = 1'b0;
      ec   = 4'd0;
      widx = -1;
      if (dm) begin
        en = 1'b1;
        ec = 4'hF;
      end else if (di && (mp != 0)) begin
        en = 1'b1;
        for (int i = NCH - 1; i >= 0; i--)
          if (mp[i]) widx = i;
        ec = 4'(widx);
        mp[widx] = 1'b0;
      end
      start_nmi(di, dm, seen, w);
      chk($sformatf("rnd%0d_start", r), seen, en);
      if (en) begin
        chk($sformatf("rnd%0d_cause", r), nmi_cause, ec);
        chk($sformatf("rnd%0d_width", r), w, 4);
        mid = 4'($urandom);
        mp  = mp | (mid & m);
        handler(mid);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/znmi_ctrl.md
ZNMI_CTRL -- requirements
Module: znmi_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4: number of deferred NMI request channels (2..8).
REQ-002 SHALL have parameter PULSE_LEN, default 4: gen_nmi width in zpos strobes (1..15).
REQ-003 SHALL have parameter CLR_RFSH, default 2: refresh falling edges between clr_nmi and in_nmi drop (1..7).
REQ-004 SHALL have parameter WDT_LEN, default 255: watchdog limit in zpos strobes (only used with ZNMI_WATCHDOG_EN).
REQ-005 SHALL have ports, one clock, reset asynchronous active-low:
 fclk  in  1  system clock
 rst_n  in  1  async active-low reset
 zpos, zneg  in  1  Z80 clock edge strobes
 int_start  in  1  frame INT start pulse
 req_n  in  NCH  deferred requests, falling edge arms channel
 req_mask  in  NCH  1 = channel enabled
 imm_nmi  in  1  immediate request (breakpoint), rising edge
 clr_nmi  in  1  one-fclk exit pulse from port write
 rfsh_n, m1_n, mreq_n  in  1  Z80 bus controls
 csrom  in  1  ROM selected
 a  in  16  Z80 address
 drive_00  out  1  force NOP onto data bus
 in_nmi  out  1  NMI RAM page mapped at 0000-3FFF
 gen_nmi  out  1  drive NMI_N low
 nmi_buf_clr  out  1  clear zmem read buffer
 nmi_cause  out  4  serviced source: channel index, or 4'hF for imm_nmi
 nmi_abort  out  1  one-fclk pulse on watchdog abort

Function
REQ-006 SHALL register req_n/imm_nmi each fclk; request event = req_n 1->0 with req_mask bit set, or imm_nmi 0->1.
REQ-007 SHALL keep pending[NCH] bits; set on event, cleared only when the channel is serviced or on reset; int_start does not clear unserviced bits.
REQ-008 SHALL start NMI on int_start when any pending bit set, idle state; lowest index wins; only winner cleared.
REQ-009 SHALL start NMI on imm_nmi event in idle state regardless of int_start; imm beats simultaneous deferred start; pending bits kept.
REQ-010 SHALL ignore imm_nmi events outside idle; deferred events outside idle still set pending.
REQ-011 SHALL latch nmi_cause at start, held until next start.
REQ-012 SHALL implement states IDLE, PULSE, WAIT66, PAGED, CLRWAIT.
REQ-013 IDLE->PULSE on start; gen_nmi=1 in PULSE, decremented on zpos; PULSE->WAIT66 after PULSE_LEN zpos strobes.
REQ-014 SHALL track M1 fetches: m1_n sampled on zpos, mreq_n on zneg, fetch edge = first fclk both low; on fetch edge record a==16'h0066 and csrom&&a[15:14]==0.
REQ-015 In WAIT66 or PULSE with last fetch ==0066: drive_00 = !m1_n && !mreq_n; nmi_buf_clr=1.
REQ-016 rfsh_n falling edge (double-registered, zpos sampled) with last fetch ==0066 -> PAGED, in_nmi=1 next fclk.
REQ-017 clr_nmi in PAGED or CLRWAIT (re)loads counter to CLR_RFSH, enters CLRWAIT; each rfsh_n falling edge decrements; at zero in_nmi=0, ->IDLE.
REQ-018 clr_nmi in IDLE, PULSE or WAIT66 SHALL be ignored.
REQ-019 Pending deferred channel SHALL be serviced at next int_start after return to IDLE.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, pending=0, counters=0, all outputs 0, nmi_cause=0, edge registers to inactive (req_n 1s, imm_nmi 0).
REQ-021 Reset mid-NMI SHALL drop gen_nmi, drive_00, in_nmi immediately with no pulse on release.

Configuration
REQ-022 With ZNMI_WATCHDOG_EN defined: counter counts zpos in PULSE/WAIT66; reaching WDT_LEN -> IDLE, nmi_abort pulse, no in_nmi; counter reset on state change.
REQ-023 Without ZNMI_WATCHDOG_EN: no watchdog logic, nmi_abort tied 0, WAIT66 held indefinitely.

Structure
REQ-024 Shared package znmi_pkg SHALL hold state encoding, CAUSE_IMM=4'hF, NMI_VECTOR=16'h0066.
REQ-025 Sub-module znmi_busmon SHALL hold M1/refresh sampling and yield fetch-edge, last_0066, last_rom, rfsh_fall.

Verification
REQ-026 req_n[2] fall, int_start 100 cycles later -> gen_nmi high for 4 zpos, nmi_cause=2, pending[2]=0.
REQ-027 req_n[1] and req_n[3] fall, then int_start twice across full NMI cycles -> causes 1 then 3.
REQ-028 imm_nmi rise same fclk as int_start with pending[0] -> nmi_cause=F, pending[0] retained.
REQ-029 M1 at 0066 -> drive_00 during fetch, in_nmi=1 after rfsh fall; clr_nmi -> in_nmi=0 after exactly 2 rfsh falls.
REQ-030 With ZNMI_WATCHDOG_EN, no 0066 fetch -> nmi_abort after 255 zpos, in_nmi stays 0, IDLE.
REQ-031 rst_n low during PAGED -> in_nmi, gen_nmi, drive_00 all 0 same cycle; no NMI on release.
